// File: rtl/alu_issue_ctrl.sv
// Issue stage for the 32-bit ALU: registers one op, waits its latency,
// then captures the result and offers it downstream with valid/ready.
//
// state | meaning
// IDLE  | no op in flight, ready to accept
// EXEC  | operands held on the ALU, counting down latency
// DONE  | result captured, waiting for downstream to take it
module alu_issue_ctrl #(
  parameter int N       = 32,
  parameter int MUL_LAT = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [2:0]   in_sel,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_sel,
  input  logic [N-1:0] alu_out,
  input  logic         alu_carry,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic         res_carry,
  output logic [2:0]   res_sel,
  output logic         res_div0,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_MUL = 3'b010;
  localparam logic [2:0] SEL_DIV = 3'b011;
  localparam logic [7:0] MUL_CNT_INIT = 8'(MUL_LAT - 1);

  state_t       state, state_nxt;
  logic [7:0]   cnt, cnt_nxt;
  logic [N-1:0] alu_a_nxt, alu_b_nxt, res_data_nxt;
  logic [2:0]   alu_sel_nxt, res_sel_nxt;
  logic         res_valid_nxt, res_carry_nxt, res_div0_nxt;
  logic         accept, div0;

  assign in_ready = (state == IDLE) || ((state == DONE) && res_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign div0     = (alu_sel == SEL_DIV) && (alu_b == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= SEL_ADD;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_sel   <= SEL_ADD;
      res_div0  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      alu_a     <= alu_a_nxt;
      alu_b     <= alu_b_nxt;
      alu_sel   <= alu_sel_nxt;
      res_valid <= res_valid_nxt;
      res_data  <= res_data_nxt;
      res_carry <= res_carry_nxt;
      res_sel   <= res_sel_nxt;
      res_div0  <= res_div0_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    alu_a_nxt     = alu_a;
    alu_b_nxt     = alu_b;
    alu_sel_nxt   = alu_sel;
    res_valid_nxt = res_valid;
    res_data_nxt  = res_data;
    res_carry_nxt = res_carry;
    res_sel_nxt   = res_sel;
    res_div0_nxt  = res_div0;

    case (state)
      IDLE: ;
      EXEC: begin
        if (cnt != 8'd0) begin
          cnt_nxt = cnt - 8'd1;
        end else begin
          res_valid_nxt = 1'b1;
          res_sel_nxt   = alu_sel;
          res_data_nxt  = div0 ? '1 : alu_out;
          res_carry_nxt = div0 ? 1'b0 : alu_carry;
          res_div0_nxt  = div0;
          // dropping sel back to add ends the multiplier start pulse
          alu_sel_nxt   = SEL_ADD;
          state_nxt     = DONE;
        end
      end
      DONE: begin
        if (res_valid && res_ready) begin
          res_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // a new op may be taken in IDLE or in the same cycle DONE retires
    if (accept) begin
      alu_a_nxt   = in_a;
      alu_b_nxt   = in_b;
      alu_sel_nxt = in_sel;
      cnt_nxt     = (in_sel == SEL_MUL) ? MUL_CNT_INIT : 8'd0;
      state_nxt   = EXEC;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU model on the
// alu_* side; expected results are hand-computed constants.
module tb_alu_issue_ctrl;

  localparam int N = 32;
  localparam int MUL_LAT = 36;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [N-1:0] in_a, in_b;
  logic [2:0]   in_sel;
  logic [N-1:0] alu_a, alu_b, alu_out;
  logic [2:0]   alu_sel;
  logic         alu_carry;
  logic         res_valid, res_ready;
  logic [N-1:0] res_data;
  logic         res_carry, res_div0, busy;
  logic [2:0]   res_sel;

  int tests = 0;
  int fails = 0;

  alu_issue_ctrl #(.N(N), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry),
    .res_sel(res_sel), .res_div0(res_div0), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [N:0] wide;
  always_comb begin
    wide = '0;
    case (alu_sel)
      3'b000: wide = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001: wide = {1'b0, alu_a} - {1'b0, alu_b};
      3'b010: wide = {1'b0, alu_a * alu_b};
      3'b011: wide = (alu_b == '0) ? '0 : {1'b0, alu_a / alu_b};
      3'b100: wide = {1'b0, alu_a << alu_b[4:0]};
      3'b101: wide = {1'b0, alu_a >> alu_b[4:0]};
      3'b110: wide = {1'b0, alu_a & alu_b};
      default: wide = {1'b0, alu_a | alu_b};
    endcase
  end
  assign alu_out   = wide[N-1:0];
  assign alu_carry = wide[N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // accept one op, then wait (bounded) for res_valid; lat = edges after accept
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [2:0] sel, output int lat);
    in_a = a; in_b = b; in_sel = sel; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_a = '0; in_b = '0; in_sel = 3'b111;
    check("exec_in_ready", in_ready, 0);
    check("exec_busy", busy, 1);
    lat = 0;
    while (!res_valid && lat < 200) begin
      check("hold_alu_a", alu_a, a);
      check("hold_alu_b", alu_b, b);
      check("hold_alu_sel", alu_sel, sel);
      step();
      lat++;
    end
    check("res_valid_seen", res_valid, 1);
  endtask

  task automatic retire();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("retire_valid", res_valid, 0);
    check("retire_busy", busy, 0);
  endtask

  int lat;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    in_a = '0; in_b = '0; in_sel = '0;
    step(); step();
    check("rst_res_valid", res_valid, 0);
    check("rst_alu_sel", alu_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_res_data", res_data, 0);
    rst_n = 1'b1;
    step();

    run_op(32'd5, 32'd7, 3'b000, lat);
    check("add_lat", lat, 1);
    check("add_data", res_data, 12);
    check("add_carry", res_carry, 0);
    check("add_sel", res_sel, 0);
    check("add_div0", res_div0, 0);
    check("done_alu_sel", alu_sel, 0);
    check("done_in_ready", in_ready, 0);
    retire();

    run_op(32'hFFFF_FFFF, 32'd1, 3'b000, lat);
    check("carry_data", res_data, 0);
    check("carry_carry", res_carry, 1);
    retire();

    run_op(32'd3, 32'd4, 3'b010, lat);
    check("mul_lat", lat, MUL_LAT);
    check("mul_data", res_data, 12);
    check("mul_sel", res_sel, 3'b010);
    check("mul_alu_sel_after", alu_sel, 0);
    retire();

    run_op(32'd10, 32'd0, 3'b011, lat);
    check("div0_data", res_data, 32'hFFFF_FFFF);
    check("div0_flag", res_div0, 1);
    check("div0_carry", res_carry, 0);
    retire();

    run_op(32'd10, 32'd2, 3'b011, lat);
    check("div_data", res_data, 5);
    check("div_flag", res_div0, 0);
    retire();

    run_op(32'd20, 32'd22, 3'b000, lat);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", res_valid, 1);
      check("bp_data", res_data, 42);
      check("bp_in_ready", in_ready, 0);
    end
    res_ready = 1'b1;
    #0;
    check("b2b_in_ready", in_ready, 1);
    in_a = 32'd9; in_b = 32'd4; in_sel = 3'b001; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("b2b_valid_clr", res_valid, 0);
    check("b2b_busy", busy, 1);
    check("b2b_alu_sel", alu_sel, 3'b001);
    check("b2b_in_ready", in_ready, 0);
    step();
    check("b2b_valid", res_valid, 1);
    check("b2b_data", res_data, 5);
    check("b2b_sel", res_sel, 3'b001);
    step();
    res_ready = 1'b0;
    check("b2b_retired", res_valid, 0);

    in_a = 32'd3; in_b = 32'd4; in_sel = 3'b010; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    step();
    check("midrst_valid", res_valid, 0);
    check("midrst_alu_sel", alu_sel, 0);
    check("midrst_busy", busy, 0);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    step();

    run_op(32'd1, 32'd1, 3'b000, lat);
    check("post_data", res_data, 2);
    retire();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Upstream issue stage for the 32-bit ALU. Accepts one operation per valid/ready handshake and drives the ALU operand and select inputs as registers, held stable.
- Waits the op-dependent latency: 1 cycle for single-cycle ops, MUL_LAT cycles for the sequential Booth multiply (sel 010).
- Captures the ALU result and carry into an output register and presents them downstream with a valid/ready handshake.
- Single outstanding op; back-to-back issue is supported.

Parameters:
- N, 32, operand/result width; must match the ALU width.
- MUL_LAT, 36, cycles the operands are held before the result is sampled for sel 010; legal range 1..255.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  op accepted when in_valid & in_ready at a clk edge.
- in_a  in  N  operand A.
- in_b  in  N  operand B.
- in_sel  in  3  ALU op code (000 add, 001 sub, 010 mul, 011 div, 100 shl, 101 shr, 110 and, 111 or).
- alu_a  out  N  registered operand A to the ALU.
- alu_b  out  N  registered operand B to the ALU.
- alu_sel  out  3  registered op code to the ALU.
- alu_out  in  N  ALU result.
- alu_carry  in  1  ALU carry out.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts the result.
- res_data  out  N  captured result.
- res_carry  out  1  captured carry.
- res_sel  out  3  op code of the captured result.
- res_div0  out  1  result came from a divide by zero.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: rst_n sampled low at an edge sets state=IDLE, cnt=0, and all registered outputs to 0 (alu_a, alu_b, alu_sel, res_valid, res_data, res_carry, res_sel, res_div0). Any in-flight op is dropped, including one reset mid-EXEC or mid-DONE.
- in_ready is combinational: 1 in IDLE; equals res_ready in DONE; 0 in EXEC. It is therefore 1 after the first reset edge.
- Counter: 8-bit cnt.
- IDLE, on accept:
  - latch alu_a=in_a, alu_b=in_b, alu_sel=in_sel;
  - cnt = MUL_LAT-1 if in_sel==010, else 0;
  - go to EXEC.
- EXEC:
  - If cnt != 0: cnt-- and stay.
  - If cnt == 0: capture res_data=alu_out, res_carry=alu_carry, res_sel=alu_sel, res_div0=0; set res_valid=1; drive alu_sel=000; go to DONE.
- EXEC, divide by zero (alu_sel==011 and alu_b==0): capture res_data = all ones, res_carry=0, res_div0=1 instead of alu_out.
- DONE: hold res_* stable while res_valid & !res_ready.
  - res_valid & res_ready & !in_valid: clear res_valid, go to IDLE.
  - res_valid & res_ready & in_valid (simultaneous handshakes): clear res_valid, latch the new op as in IDLE, go directly to EXEC.
- Latency, with accept at edge k:
  - non-mul: res_valid high after edge k+1;
  - mul: res_valid high after edge k+MUL_LAT.
- Throughput: one op per 2 cycles for non-mul ops when res_ready is held 1.
- alu_sel returns to 000 outside EXEC (it still shows the last issued op in IDLE after reset only as 000). The multiplier start therefore pulses only during a mul EXEC.
- Operands are not modified; no width change. res_data is exactly N bits, with the high product bits discarded by the ALU.
- in_* are ignored whenever in_ready=0.

Test Plan:
- Reset, then add: a=5, b=7, sel=000 accepted at edge k -> res_valid after k+1, res_data=12, res_carry=0, res_sel=000; in_ready=0 during EXEC.
- Carry: a=FFFFFFFF, b=1, sel=000 -> res_data=0, res_carry=1.
- Mul latency with MUL_LAT=36: a=3, b=4, sel=010 -> alu_a/alu_b/alu_sel stable for 36 cycles, res_valid after k+36, res_data=12.
- Div by zero: a=10, b=0, sel=011 -> res_data=FFFFFFFF, res_div0=1. Then a=10, b=2 -> res_data=5, res_div0=0.
- Backpressure/back-to-back: hold res_ready=0 for 5 cycles -> res_* stable and in_ready=0. Then res_ready=1 with in_valid=1 (sub 9-4) in the same cycle -> first result retired, new op in EXEC next cycle, res_data=5 one cycle later.
- Reset mid-op: assert rst_n=0 at cycle 10 of a mul -> next edge: res_valid=0, alu_sel=000, busy=0, in_ready=1 after release.
